// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state and
// small decode helpers used by both the sequencer and the arithmetic block.
package mdu_pkg;

  localparam logic [3:0] MD_MULT  = 4'd3;
  localparam logic [3:0] MD_DIV   = 4'd4;
  localparam logic [3:0] MD_MULTU = 4'd8;
  localparam logic [3:0] MD_DIVU  = 4'd9;
  localparam logic [3:0] MD_MTHI  = 4'd10;
  localparam logic [3:0] MD_MTLO  = 4'd11;

  typedef enum logic [0:0] {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

  // Ops that occupy the unit for multiple cycles.
  function automatic logic is_start_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath. Produces the HI/LO values that the
// sequencer will commit once the modelled latency has elapsed.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic [31:0]        b_safe_s;
  logic [31:0]        b_safe_u;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // The divider never sees a zero divisor or INT_MIN/-1; those cases are
  // resolved explicitly below so the operator itself stays well defined.
  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == INT_MIN) && (b == NEG_ONE);
  assign b_safe_s = (div_zero || div_ovf) ? 32'd1 : b;
  assign b_safe_u = div_zero ? 32'd1 : b;

  assign quot_s = $signed(a) / $signed(b_safe_s);
  assign rem_s  = $signed(a) % $signed(b_safe_s);
  assign quot_u = a / b_safe_u;
  assign rem_u  = a % b_safe_u;

  // Select the result for the requested op; divide-by-zero preserves HI/LO.
  always_comb begin
    res_hi = cur_hi;
    res_lo = cur_lo;
    case (op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV: begin
        if (div_ovf) begin
          res_hi = 32'd0;
          res_lo = INT_MIN;
        end else if (!div_zero) begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      MD_DIVU: begin
        if (!div_zero) begin
          res_hi = rem_u;
          res_lo = quot_u;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models the fixed operation latency
// with a down-counter and requests a D-stage stall while occupied.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   MDU_IDLE | unit free; accepts mult/div starts and mthi/mtlo writes
//   MDU_BUSY | op in flight; cnt counts down, result commits when cnt==1
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_valid,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_uses_md,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  mdu_state_t       state;
  mdu_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;

  mdu_arith u_arith (
    .op     (md_op),
    .a      (rs_val),
    .b      (rt_val),
    .cur_hi (hi),
    .cur_lo (lo),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // Treat 0 as terminal too, so a corrupted counter cannot wedge the unit.
  assign cnt_last = (cnt <= CNT_W'(1));
  assign busy     = (state == MDU_BUSY);
  assign stall_md = d_uses_md & (start | busy);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= MDU_IDLE;
    else       state <= state_next;
  end

  // Next state and start decode; md_valid is ignored while busy.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      MDU_IDLE: begin
        start = md_valid & is_start_op(md_op);
        if (start) state_next = MDU_BUSY;
      end
      MDU_BUSY: begin
        if (cnt_last) state_next = MDU_IDLE;
      end
      default: state_next = MDU_IDLE;
    endcase
  end

  // Counter, pending result capture, HI/LO writes and commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (state == MDU_IDLE) begin
      if (start) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        cnt     <= is_mul_op(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      end else if (md_valid && md_op == MD_MTHI) begin
        hi <= rs_val;
      end else if (md_valid && md_op == MD_MTLO) begin
        lo <= rs_val;
      end
    end else begin
      cnt <= cnt - CNT_W'(1);
      if (cnt_last) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl. Stimulus pushes the expected commit (HI, LO,
// busy length) into a queue; a monitor pops and compares on every busy fall.
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_valid;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_uses_md;
  logic        start;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .md_valid  (md_valid),
    .md_op     (md_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .d_uses_md (d_uses_md),
    .start     (start),
    .busy      (busy),
    .stall_md  (stall_md),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: sample mid low-phase, compare each commit against the queue.
  initial begin
    logic busy_prev;
    int   len;
    exp_t e;
    busy_prev = 1'b0;
    len = 0;
    forever begin
      @(negedge clk);
      #3;
      if (busy === 1'b1) begin
        chk("no_valid_in_busy", {31'd0, md_valid}, 32'd0);
        len++;
      end else if (busy_prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_commit actual=hi %h lo %h required=no commit", hi, lo);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
          chk({e.name, "_busy_len"}, len, e.cycles);
        end
        len = 0;
      end
      busy_prev = (busy === 1'b1);
    end
  end

  // Issue one mult/div at the current (idle, low-phase) time and follow it to
  // the first idle cycle, checking start and stall_md along the way.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int n);
    int k;
    md_valid = 1'b1;
    md_op    = op;
    rs_val   = a;
    rt_val   = b;
    #1;
    chk({nm, "_start"}, {31'd0, start}, 32'd1);
    chk({nm, "_stall_start"}, {31'd0, stall_md}, {31'd0, d_uses_md});
    exp_q.push_back('{nm, eh, el, n});
    @(negedge clk);
    md_valid = 1'b0;
    md_op    = 4'd0;
    k = 0;
    while (busy && k < 30) begin
      #1;
      chk({nm, "_start_busy"}, {31'd0, start}, 32'd0);
      chk({nm, "_stall_busy"}, {31'd0, stall_md}, {31'd0, d_uses_md});
      @(negedge clk);
      k++;
    end
    if (k >= 30) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=busy stuck required=idle within 30", nm);
    end
    #1;
    chk({nm, "_stall_after"}, {31'd0, stall_md}, 32'd0);
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] v);
    md_valid = 1'b1;
    md_op    = op;
    rs_val   = v;
    rt_val   = 32'd0;
    @(negedge clk);
    md_valid = 1'b0;
    md_op    = 4'd0;
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    md_valid  = 1'b0;
    md_op     = 4'd0;
    rs_val    = 32'd0;
    rt_val    = 32'd0;
    d_uses_md = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_stall", {31'd0, stall_md}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // mflo sitting in D while the unit is busy
    run_op("mult_neg3x5", 4'd3, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MULT_N);
    d_uses_md = 1'b0;
    run_op("divu_7_2", 4'd9, 32'd7, 32'd2, 32'd1, 32'd3, DIV_N);
    run_op("div_m7_2", 4'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N);

    move_to(4'd10, 32'h1234_5678);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    run_op("div_by0", 4'd4, 32'd99, 32'd0, 32'h1234_5678, 32'hFFFF_FFFD, DIV_N);

    move_to(4'd11, 32'hA5A5_A5A5);
    chk("mtlo_lo", lo, 32'hA5A5_A5A5);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    d_uses_md = 1'b1;
    run_op("mult_min_x_m1", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, MULT_N);

    // back-to-back starts in the first idle cycle
    run_op("multu_max", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULT_N);
    run_op("mult_maxpos", 4'd3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, MULT_N);
    run_op("div_ovf", 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_N);
    run_op("div_7_m2", 4'd4, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_N);
    run_op("divu_100_7", 4'd9, 32'd100, 32'd7, 32'd2, 32'd14, DIV_N);
    run_op("divu_by0", 4'd9, 32'hFFFF_FFFF, 32'd0, 32'd2, 32'd14, DIV_N);

    // ignored op code: no start, no state change
    md_valid = 1'b1;
    md_op    = 4'd5;
    #1;
    chk("badop_start", {31'd0, start}, 32'd0);
    @(negedge clk);
    md_valid = 1'b0;
    #1;
    chk("badop_busy", {31'd0, busy}, 32'd0);
    chk("badop_hi", hi, 32'd2);

    // reset during the third busy cycle aborts the multiply
    d_uses_md = 1'b0;
    md_valid  = 1'b1;
    md_op     = 4'd3;
    rs_val    = 32'd6;
    rt_val    = 32'd7;
    exp_q.push_back('{"rst_abort", 32'd0, 32'd0, 3});
    @(negedge clk);
    md_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("abort_no_late_lo", lo, 32'd0);
      chk("abort_no_late_busy", {31'd0, busy}, 32'd0);
    end

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1, "timeout");
  end

endmodule
